// File: rtl/seg_display_scanner.sv
// Multiplexed 7-segment scanner: time-slices DIGITS digits, hex-decodes, PWM-dims,
// and swaps in newly loaded data only at frame boundaries so a frame never tears.
module seg_display_scanner #(
    parameter int DIGITS     = 4,
    parameter int DIV_W      = 17,
    parameter int PWM_W      = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic                  load,
    input  logic                  lz_en,
    input  logic [PWM_W-1:0]      brightness,
    output logic                  load_ack,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            seg,
    output logic                  frame_tick
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic INV = (ACTIVE_LOW != 0);

    logic [DIV_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic                term, wrap, wrap_q;

    logic [4*DIGITS-1:0] pend_dig, disp_dig;
    logic [DIGITS-1:0]   pend_dp, disp_dp, pend_blank, disp_blank;
    logic                pend_v;

    assign term = &cnt;
    assign wrap = term && (idx == LAST_IDX);

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1111110;
            4'h1: hex7 = 7'b0110000;
            4'h2: hex7 = 7'b1101101;
            4'h3: hex7 = 7'b1111001;
            4'h4: hex7 = 7'b0110011;
            4'h5: hex7 = 7'b1011011;
            4'h6: hex7 = 7'b1011111;
            4'h7: hex7 = 7'b1110000;
            4'h8: hex7 = 7'b1111111;
            4'h9: hex7 = 7'b1110011;
            4'hA: hex7 = 7'b1110111;
            4'hB: hex7 = 7'b0011111;
            4'hC: hex7 = 7'b1001110;
            4'hD: hex7 = 7'b0111101;
            4'hE: hex7 = 7'b1001111;
            default: hex7 = 7'b1000111;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= cnt + 1'b1;
            if (term)
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
    end

    // A load landing on the wrap cycle bypasses pending and goes straight to display.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_dig   <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            pend_v     <= 1'b0;
            disp_dig   <= '0;
            disp_dp    <= '0;
            disp_blank <= '0;
            load_ack   <= 1'b0;
            wrap_q     <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            wrap_q     <= wrap;
            frame_tick <= wrap_q;
            if (wrap) begin
                if (load) begin
                    disp_dig   <= digits_in;
                    disp_dp    <= dp_in;
                    disp_blank <= blank_in;
                end else if (pend_v) begin
                    disp_dig   <= pend_dig;
                    disp_dp    <= pend_dp;
                    disp_blank <= pend_blank;
                end
                load_ack <= load || pend_v;
                pend_v   <= 1'b0;
            end else begin
                load_ack <= 1'b0;
                if (load) begin
                    pend_dig   <= digits_in;
                    pend_dp    <= dp_in;
                    pend_blank <= blank_in;
                    pend_v     <= 1'b1;
                end
            end
        end
    end

    logic [DIGITS-1:0] supp;
    logic              lead;
    logic [3:0]        cur_nib;
    logic              cur_dp, cur_blank, cur_supp, pwm_on;
    logic [PWM_W-1:0]  pwm_lvl;
    logic [DIGITS-1:0] an_raw;
    logic [7:0]        seg_raw;

    // Zero run from the top digit down is suppressed; digit 0 always shows.
    always_comb begin
        supp = '0;
        lead = lz_en;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lead    = lead && (disp_dig[4*i +: 4] == 4'h0);
            supp[i] = lead;
        end
    end

    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_supp  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib   = disp_dig[4*i +: 4];
                cur_dp    = disp_dp[i];
                cur_blank = disp_blank[i];
                cur_supp  = supp[i];
            end
        end
        pwm_lvl = cnt[DIV_W-1 -: PWM_W];
        pwm_on  = (&brightness) || (pwm_lvl < brightness);
        an_raw  = '0;
        for (int i = 0; i < DIGITS; i++)
            an_raw[i] = (idx == IDX_W'(i)) && pwm_on && !cur_blank;
        seg_raw = cur_blank ? 8'h00 : {cur_dp, cur_supp ? 7'b0 : hex7(cur_nib)};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= {DIGITS{INV}};
            seg <= {8{INV}};
        end else begin
            an  <= an_raw ^ {DIGITS{INV}};
            seg <= seg_raw ^ {8{INV}};
        end
    end
endmodule

// File: doc/seg_display_scanner.md
SEG_DISPLAY_SCANNER -- requirements
Module: seg_display_scanner

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed digits, range 1..16.
REQ-002 Parameter DIV_W, default 17: slot counter width; each digit slot lasts 2^DIV_W clk cycles; DIV_W >= PWM_W+1.
REQ-003 Parameter PWM_W, default 4: brightness resolution in bits.
REQ-004 Parameter ACTIVE_LOW, default 1: 1 = an and seg driven active-low; 0 = active-high.
REQ-005 clk  input  1  system clock, rising-edge.
REQ-006 reset  input  1  asynchronous, active-high.
REQ-007 digits_in  input  4*DIGITS  hex nibble per digit; digit i = bits [4i+3:4i]; digit 0 is rightmost.
REQ-008 dp_in  input  DIGITS  decimal point per digit.
REQ-009 blank_in  input  DIGITS  1 = force digit i dark.
REQ-010 load  input  1  single-cycle request to capture digits_in/dp_in/blank_in.
REQ-011 lz_en  input  1  leading-zero suppression enable, level, sampled every cycle.
REQ-012 brightness  input  PWM_W  duty level, sampled every cycle.
REQ-013 load_ack  output  1  one-cycle pulse when captured data becomes visible.
REQ-014 an  output  DIGITS  digit enables.
REQ-015 seg  output  8  {dp,a,b,c,d,e,f,g}; seg[7]=dp, seg[6]=a, seg[0]=g.
REQ-016 frame_tick  output  1  one-cycle pulse when scan index wraps to digit 0.

Function
REQ-017 Slot counter SHALL increment by 1 every cycle, wrapping at 2^DIV_W-1; at terminal count the digit index SHALL advance by 1, wrapping from DIGITS-1 to 0.
REQ-018 Exactly one digit SHALL be enabled at a time; others held inactive.
REQ-019 an and seg SHALL be registered: they reflect the counter/index state of the previous cycle (one-cycle latency).
REQ-020 Hex decode (logical 1 = lit, abcdefg): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1110011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111; output inverted when ACTIVE_LOW=1.
REQ-021 PWM: the current digit's an is active only while slot counter bits [DIV_W-1:DIV_W-PWM_W] < brightness, or for the whole slot when brightness is all ones; brightness 0 means dark.
REQ-022 Captured data SHALL be held in a pending register; pending SHALL be copied to the display register only on the cycle the index wraps DIGITS-1 -> 0 (no tearing mid-frame).
REQ-023 load_ack SHALL pulse the cycle after the copy; no ack if nothing pending.
REQ-024 Multiple loads before a wrap: last one wins, single ack.
REQ-025 Load in the same cycle as the wrap: new data is copied directly at that wrap, ack the next cycle.
REQ-026 Leading-zero suppression (lz_en=1): starting at digit DIGITS-1, consecutive zero nibbles are dark (segments a-g off) until the first nonzero digit; digit 0 is never suppressed; dp of a suppressed digit is still shown.
REQ-027 blank_in digit: an inactive for the whole slot, dp included; overrides REQ-026.
REQ-028 frame_tick SHALL pulse the same cycle an first selects digit 0 of a new frame.

Reset
REQ-029 While reset is high: counter=0, index=0, pending and display registers=0, pending flag=0, an all inactive, seg all off, load_ack=0, frame_tick=0.
REQ-030 Reset asserted mid-frame or mid-load SHALL discard pending data without ack.
REQ-031 The first clock after reset release SHALL begin slot 0 of digit 0 with display data 0.

Verification (DIGITS=4, DIV_W=4, PWM_W=2, ACTIVE_LOW=1; slot=16, frame=64 cycles)
REQ-032 load digits=0x12AF, dp=0001, brightness=3 -> after the next wrap, an cycles 1110,1101,1011,0111 for 16 cycles each; seg = ~{1,1000111}, ~{0,1110111}, ~{0,1101101}, ~{0,0110000}; load_ack one pulse.
REQ-033 brightness=1 -> each digit's an active for 4 of 16 slot cycles; brightness=0 -> an stays 1111.
REQ-034 lz_en=1, digits=0x0030 -> digits 3 and 2 dark, digit 1 shows 3, digit 0 shows 0; digits=0x0000 -> only digit 0 lit.
REQ-035 Loads of 0x1111 then 0x2222 mid-frame -> display unchanged until wrap, then 0x2222, exactly one load_ack.
REQ-036 Load coincident with wrap cycle -> new data visible in that frame, ack next cycle; reset pulse mid-frame with a pending load -> all outputs off, no ack, display 0 after release.
